// File: rtl/pipe_pkg.sv
// Shared opcode encodings, sequencing states and register-read decode
// for the 5-stage pipeline control.
package pipe_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ATYPE = 4'b0001;
    localparam logic [3:0] OP_JMP   = 4'b0010;
    localparam logic [3:0] OP_HALT  = 4'b0011;
    localparam logic [3:0] OP_LBU   = 4'b0100;
    localparam logic [3:0] OP_SB    = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0111;
    localparam logic [3:0] OP_AND   = 4'b1001;
    localparam logic [3:0] OP_OR    = 4'b1010;
    localparam logic [3:0] OP_BLT   = 4'b1100;
    localparam logic [3:0] OP_BGT   = 4'b1101;
    localparam logic [3:0] OP_BEQ   = 4'b1110;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LBU) || (op == OP_LW);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BLT) || (op == OP_BGT) || (op == OP_BEQ);
    endfunction

    function automatic logic reads_src1(input logic [3:0] op);
        return (op == OP_ATYPE) || (op == OP_SB) || (op == OP_SW) ||
               (op == OP_AND)   || (op == OP_OR) || is_branch(op);
    endfunction

    function automatic logic reads_src2(input logic [3:0] op);
        return (op == OP_ATYPE) || (op == OP_SB) || (op == OP_SW) ||
               is_load(op)      || is_branch(op);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use and taken-branch detection between the EX and ID
// stages.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int OPW = 4,
    parameter int RW  = 4
) (
    input  logic [OPW-1:0] op_ex,
    input  logic [RW-1:0]  dest_ex,
    input  logic [OPW-1:0] op_id,
    input  logic [RW-1:0]  src1_id,
    input  logic [RW-1:0]  src2_id,
    input  logic           branch_taken_ex,
    output logic           load_use,
    output logic           br_taken
);

    logic src1_hit;
    logic src2_hit;

    assign src1_hit = reads_src1(op_id) && (src1_id == dest_ex);
    assign src2_hit = reads_src2(op_id) && (src2_id == dest_ex);

    assign load_use = is_load(op_ex) && (src1_hit || src2_hit);
    assign br_taken = is_branch(op_ex) && branch_taken_ex;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: carries ID fields through EX/MEM/WB, resolves
// branch/load-use/jump/halt priority and drains the pipe after HALT.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int OPW          = 4,
    parameter int RW           = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] op_id,
    input  logic [OPW-1:0] func_id,
    input  logic [RW-1:0]  src1_id,
    input  logic [RW-1:0]  src2_id,
    input  logic [RW-1:0]  dest_id,
    input  logic           branch_taken_ex,
    output logic [OPW-1:0] op_ex,
    output logic [OPW-1:0] op_mem,
    output logic [OPW-1:0] op_wb,
    output logic [OPW-1:0] func_wb,
    output logic [RW-1:0]  dest_ex,
    output logic [RW-1:0]  dest_mem,
    output logic [RW-1:0]  dest_wb,
    output logic           stall,
    output logic           flush_ifid,
    output logic           redirect,
    output logic           halted
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [OPW-1:0] op_ex_q, op_mem_q, op_wb_q;
    logic [OPW-1:0] func_ex_q, func_mem_q, func_wb_q;
    logic [RW-1:0]  dest_ex_q, dest_mem_q, dest_wb_q;
    logic [OPW-1:0] op_ex_d, func_ex_d;
    logic [RW-1:0]  dest_ex_d;

    logic load_use;
    logic br_taken;

    hazard_detect #(
        .OPW(OPW),
        .RW (RW)
    ) u_hazard (
        .op_ex          (op_ex_q),
        .dest_ex        (dest_ex_q),
        .op_id          (op_id),
        .src1_id        (src1_id),
        .src2_id        (src2_id),
        .branch_taken_ex(branch_taken_ex),
        .load_use       (load_use),
        .br_taken       (br_taken)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        flush_ifid = 1'b0;
        redirect   = 1'b0;
        op_ex_d    = '0;
        func_ex_d  = '0;
        dest_ex_d  = '0;

        case (state_q)
            RUN: begin
                if (br_taken) begin
                    redirect   = 1'b1;
                    flush_ifid = 1'b1;
                end else if (load_use) begin
                    stall = 1'b1;
                end else begin
                    op_ex_d   = op_id;
                    func_ex_d = func_id;
                    dest_ex_d = dest_id;
                    if (op_id == OP_HALT) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(DRAIN_CYCLES - 1);
                    end else if (op_id == OP_JMP) begin
                        redirect   = 1'b1;
                        flush_ifid = 1'b1;
                    end
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            op_ex_q    <= '0;
            op_mem_q   <= '0;
            op_wb_q    <= '0;
            func_ex_q  <= '0;
            func_mem_q <= '0;
            func_wb_q  <= '0;
            dest_ex_q  <= '0;
            dest_mem_q <= '0;
            dest_wb_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_ex_q    <= op_ex_d;
            func_ex_q  <= func_ex_d;
            dest_ex_q  <= dest_ex_d;
            op_mem_q   <= op_ex_q;
            func_mem_q <= func_ex_q;
            dest_mem_q <= dest_ex_q;
            op_wb_q    <= op_mem_q;
            func_wb_q  <= func_mem_q;
            dest_wb_q  <= dest_mem_q;
        end
    end

    assign op_ex    = op_ex_q;
    assign op_mem   = op_mem_q;
    assign op_wb    = op_wb_q;
    assign func_wb  = func_wb_q;
    assign dest_ex  = dest_ex_q;
    assign dest_mem = dest_mem_q;
    assign dest_wb  = dest_wb_q;
    assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a queue of expected EX contents is checked
// as each entry moves through EX, MEM and WB.
module tb_pipe_ctrl;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] func;
        logic [3:0] dest;
    } slot_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] op_id, func_id, src1_id, src2_id, dest_id;
    logic       branch_taken_ex;
    logic [3:0] op_ex, op_mem, op_wb, func_wb;
    logic [3:0] dest_ex, dest_mem, dest_wb;
    logic       stall, flush_ifid, redirect, halted;

    int vectors     = 0;
    int miscompares = 0;
    slot_t sb_q[$];

    pipe_ctrl #(
        .OPW         (4),
        .RW          (4),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_id          (op_id),
        .func_id        (func_id),
        .src1_id        (src1_id),
        .src2_id        (src2_id),
        .dest_id        (dest_id),
        .branch_taken_ex(branch_taken_ex),
        .op_ex          (op_ex),
        .op_mem         (op_mem),
        .op_wb          (op_wb),
        .func_wb        (func_wb),
        .dest_ex        (dest_ex),
        .dest_mem       (dest_mem),
        .dest_wb        (dest_wb),
        .stall          (stall),
        .flush_ifid     (flush_ifid),
        .redirect       (redirect),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic sb_reset();
        sb_q.delete();
        repeat (3) sb_q.push_back('0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".op_ex"},   op_ex,   4'h0);
        chk({tag, ".op_mem"},  op_mem,  4'h0);
        chk({tag, ".op_wb"},   op_wb,   4'h0);
        chk({tag, ".func_wb"}, func_wb, 4'h0);
        chk({tag, ".dest_wb"}, dest_wb, 4'h0);
        chk({tag, ".ctl"},     {1'b0, stall, flush_ifid, redirect}, 4'h0);
        chk({tag, ".halted"},  {3'b0, halted}, 4'h0);
    endtask

    // ctl = {stall, flush_ifid, redirect}; adv selects ID fields or a bubble into EX.
    task automatic step(input string tag, input logic [3:0] op, input logic [3:0] fn,
                        input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                        input logic bt, input logic [2:0] ctl, input logic adv,
                        input logic exp_h);
        slot_t e_ex, e_mem, e_wb;
        @(negedge clk);
        op_id = op; func_id = fn; src1_id = s1; src2_id = s2; dest_id = d;
        branch_taken_ex = bt;
        #1;
        chk({tag, ".ctl"}, {1'b0, stall, flush_ifid, redirect}, {1'b0, ctl});
        sb_q.push_back(adv ? slot_t'{op, fn, d} : slot_t'('0));
        @(posedge clk);
        #1;
        e_ex  = sb_q[$];
        e_mem = sb_q[$-1];
        e_wb  = sb_q[$-2];
        chk({tag, ".op_ex"},    op_ex,    e_ex.op);
        chk({tag, ".dest_ex"},  dest_ex,  e_ex.dest);
        chk({tag, ".op_mem"},   op_mem,   e_mem.op);
        chk({tag, ".dest_mem"}, dest_mem, e_mem.dest);
        chk({tag, ".op_wb"},    op_wb,    e_wb.op);
        chk({tag, ".func_wb"},  func_wb,  e_wb.func);
        chk({tag, ".dest_wb"},  dest_wb,  e_wb.dest);
        chk({tag, ".halted"},   {3'b0, halted}, {3'b0, exp_h});
        while (sb_q.size() > 3) void'(sb_q.pop_front());
    endtask

    initial begin
        rst_n = 1'b0;
        op_id = '0; func_id = '0; src1_id = '0; src2_id = '0; dest_id = '0;
        branch_taken_ex = 1'b0;
        sb_reset();
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // straight-line flow, no register overlap
        step("line0", 4'b0001, 4'h2, 4'h1, 4'h2, 4'h3, 1'b0, 3'b000, 1'b1, 1'b0);
        step("line1", 4'b1001, 4'h4, 4'h4, 4'h0, 4'h6, 1'b0, 3'b000, 1'b1, 1'b0);
        step("line2", 4'b0110, 4'h5, 4'h0, 4'h7, 4'h5, 1'b0, 3'b000, 1'b1, 1'b0);
        // LW dest 5 in EX, A-type reads src2=5: one bubble then advance
        step("lu_stall", 4'b0001, 4'h1, 4'h8, 4'h5, 4'h9, 1'b0, 3'b100, 1'b0, 1'b0);
        step("lu_go",    4'b0001, 4'h1, 4'h8, 4'h5, 4'h9, 1'b0, 3'b000, 1'b1, 1'b0);
        // taken BEQ squashes the A-type in ID
        step("beq_in",   4'b1110, 4'h0, 4'h1, 4'h2, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0);
        step("beq_tkn",  4'b0001, 4'h3, 4'h1, 4'h2, 4'hA, 1'b1, 3'b011, 1'b0, 1'b0);
        // taken BLT while ID reads the register named by EX dest
        step("blt_in",   4'b1100, 4'h0, 4'h2, 4'h3, 4'hB, 1'b0, 3'b000, 1'b1, 1'b0);
        step("blt_tkn",  4'b0001, 4'h0, 4'hB, 4'hB, 4'hC, 1'b1, 3'b011, 1'b0, 1'b0);
        step("jmp",      4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b011, 1'b1, 1'b0);
        // LBU then OR reading src1: stall; LW then AND with overlap only on src2: none
        step("lbu",      4'b0100, 4'h0, 4'h0, 4'h1, 4'h7, 1'b0, 3'b000, 1'b1, 1'b0);
        step("or_stall", 4'b1010, 4'h0, 4'h7, 4'h0, 4'h8, 1'b0, 3'b100, 1'b0, 1'b0);
        step("or_go",    4'b1010, 4'h0, 4'h7, 4'h0, 4'h8, 1'b0, 3'b000, 1'b1, 1'b0);
        step("lw",       4'b0110, 4'h0, 4'h0, 4'h1, 4'h4, 1'b0, 3'b000, 1'b1, 1'b0);
        step("and_src2", 4'b1001, 4'h0, 4'h1, 4'h4, 4'h2, 1'b0, 3'b000, 1'b1, 1'b0);
        // halt drain with SW in EX and OR in MEM at cycle N
        step("or_h",     4'b1010, 4'h6, 4'h1, 4'h0, 4'h3, 1'b0, 3'b000, 1'b1, 1'b0);
        step("sw_h",     4'b0111, 4'h7, 4'h2, 4'h3, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0);
        step("halt_N",   4'b0011, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0);
        step("drain1",   4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b100, 1'b0, 1'b0);
        chk("sw_in_wb", op_wb, 4'b0111);
        step("drain2",   4'b1110, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'b100, 1'b0, 1'b0);
        chk("halt_in_wb", op_wb, 4'b0011);
        step("drain3",   4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b100, 1'b0, 1'b1);
        step("halted",   4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b100, 1'b0, 1'b1);

        // reset out of HALTED
        @(negedge clk);
        op_id = '0; branch_taken_ex = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_halted");
        @(negedge clk);
        rst_n = 1'b1;
        sb_reset();

        // reset asserted asynchronously mid-DRAIN
        step("halt2",    4'b0011, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0);
        step("drain_r",  4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b100, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_drain");
        @(negedge clk);
        rst_n = 1'b1;
        sb_reset();
        step("post0",    4'b0001, 4'h9, 4'h1, 4'h2, 4'h3, 1'b0, 3'b000, 1'b1, 1'b0);
        step("post1",    4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b011, 1'b1, 1'b0);
        step("post2",    4'b1010, 4'h5, 4'h4, 4'h0, 4'h6, 1'b0, 3'b000, 1'b1, 1'b0);
        step("post3",    4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
